// File: rtl/dsp_arb_pkg.sv
// Shared types and default widths for the DSP bank arbiter.
package dsp_arb_pkg;

    localparam int DEF_NUM_DSP = 16;
    localparam int DEF_OPW     = 18;
    localparam int DEF_OUTW    = 37;
    // Wide enough for the largest supported requester count (8).
    localparam int TAG_IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] owner_idx;
    } arb_tag_t;

endpackage

// File: rtl/dsp_bank_arbiter_rr_pick.sv
// Combinational round-robin search: first set request bit at or after ptr, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      idx,
    output logic               found
);

    always_comb begin
        int p;
        p     = 0;
        idx   = '0;
        found = 1'b0;
        // Walk offsets from farthest to nearest so the nearest hit wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            p = int'(ptr) + k;
            if (p >= NUM_REQ) begin
                p = p - NUM_REQ;
            end
            if (req[p]) begin
                idx   = IW'(p);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dsp_bank_arbiter.sv
// Round-robin, non-preemptive owner of a shared DSP bank with drain-on-release and
// per-result requester tagging. Define DSP_ARB_WATCHDOG_EN to add the err_hold watchdog.
module dsp_bank_arbiter
    import dsp_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int NUM_DSP  = DEF_NUM_DSP,
    parameter int OPW      = DEF_OPW,
    parameter int OUTW     = DEF_OUTW,
    parameter int DSP_LAT  = 3
`ifdef DSP_ARB_WATCHDOG_EN
    ,
    parameter int MAX_HOLD = 1024
`endif
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_REQ-1:0]                     req,
    input  logic [NUM_REQ-1:0]                     req_ce,
    input  logic [NUM_REQ-1:0][NUM_DSP-1:0][OPW-1:0] req_dsp_a,
    input  logic [NUM_REQ-1:0][NUM_DSP-1:0][OPW-1:0] req_dsp_b,
    output logic [NUM_REQ-1:0]                     gnt,
    output logic [NUM_DSP-1:0][OPW-1:0]            dsp_a,
    output logic [NUM_DSP-1:0][OPW-1:0]            dsp_b,
    output logic                                   dsp_ce,
    input  logic [NUM_DSP-1:0][OUTW-1:0]           dsp_out,
    output logic [NUM_DSP-1:0][OUTW-1:0]           rsp_data,
    output logic [NUM_REQ-1:0]                     rsp_valid,
    output logic                                   busy
`ifdef DSP_ARB_WATCHDOG_EN
    ,
    output logic                                   err_hold
`endif
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(DSP_LAT + 1);

    arb_state_t          state_q, state_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [CW-1:0]       drain_cnt_q, drain_cnt_d;
    arb_tag_t            tag_q [DSP_LAT];
    arb_tag_t            tag_d [DSP_LAT];
    arb_tag_t            tag_in;
    logic [IW-1:0]       pick_idx;
    logic                pick_found;
    logic                tag_any;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = OWN;
                    owner_d = pick_idx;
                end
            end
            OWN: begin
                if (!req[owner_q]) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                    rr_ptr_d    = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == CW'(DSP_LAT - 1)) begin
                    if (pick_found) begin
                        state_d = OWN;
                        owner_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d = '0;
        if (state_q == OWN && req[owner_q]) begin
            gnt_d[owner_q] = 1'b1;
        end
    end

    // Only the registered owner reaches the bank; drain pushes zero operands.
    always_comb begin
        dsp_a  = '0;
        dsp_b  = '0;
        dsp_ce = 1'b0;
        if (state_q == OWN) begin
            dsp_a  = req_dsp_a[owner_q];
            dsp_b  = req_dsp_b[owner_q];
            dsp_ce = req_ce[owner_q];
        end else if (state_q == DRAIN) begin
            dsp_ce = 1'b1;
        end
    end

    always_comb begin
        tag_in.valid     = (state_q == OWN) && req_ce[owner_q];
        tag_in.owner_idx = TAG_IDX_W'(owner_q);
        tag_any          = 1'b0;
        for (int k = 0; k < DSP_LAT; k++) begin
            tag_d[k] = tag_q[k];
            tag_any  = tag_any | tag_q[k].valid;
        end
        if (dsp_ce) begin
            tag_d[0] = tag_in;
            for (int k = 1; k < DSP_LAT; k++) begin
                tag_d[k] = tag_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            drain_cnt_q <= '0;
            for (int k = 0; k < DSP_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            drain_cnt_q <= drain_cnt_d;
            tag_q       <= tag_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
            assign rsp_valid[gi] = dsp_ce && tag_q[DSP_LAT-1].valid &&
                                   (tag_q[DSP_LAT-1].owner_idx == TAG_IDX_W'(gi));
        end
    endgenerate

    assign gnt      = gnt_q;
    assign rsp_data = dsp_out;
    assign busy     = (state_q != IDLE) || tag_any;

`ifdef DSP_ARB_WATCHDOG_EN
    localparam int HW = $clog2(MAX_HOLD + 1);

    logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
    logic               err_hold_q, err_hold_d;
    logic [NUM_REQ-1:0] others;
    logic               contended;

    // Counts owned cycles that someone else spent waiting; restarts on every grant.
    always_comb begin
        others          = req;
        others[owner_q] = 1'b0;
        contended       = (state_q == OWN) && (|others);
        hold_cnt_d      = hold_cnt_q;
        err_hold_d      = err_hold_q;
        if (state_q != OWN && state_d == OWN) begin
            hold_cnt_d = '0;
        end else if (contended && hold_cnt_q < HW'(MAX_HOLD)) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
        if (contended && hold_cnt_q >= HW'(MAX_HOLD - 1)) begin
            err_hold_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
            err_hold_q <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            err_hold_q <= err_hold_d;
        end
    end

    assign err_hold = err_hold_q;
`endif

endmodule

// File: tb/tb_dsp_bank_arbiter.sv
// Directed bench for dsp_bank_arbiter with a behavioural 3-stage multiplier bank.
module tb_dsp_bank_arbiter;

    localparam int NUM_REQ = 2;
    localparam int NUM_DSP = 16;
    localparam int OPW     = 18;
    localparam int OUTW    = 37;
    localparam int DSP_LAT = 3;

    logic                                     clk = 1'b0;
    logic                                     rst_n;
    logic [NUM_REQ-1:0]                       req;
    logic [NUM_REQ-1:0]                       req_ce;
    logic [NUM_REQ-1:0][NUM_DSP-1:0][OPW-1:0] req_dsp_a;
    logic [NUM_REQ-1:0][NUM_DSP-1:0][OPW-1:0] req_dsp_b;
    logic [NUM_REQ-1:0]                       gnt;
    logic [NUM_DSP-1:0][OPW-1:0]              dsp_a;
    logic [NUM_DSP-1:0][OPW-1:0]              dsp_b;
    logic                                     dsp_ce;
    logic [NUM_DSP-1:0][OUTW-1:0]             dsp_out;
    logic [NUM_DSP-1:0][OUTW-1:0]             rsp_data;
    logic [NUM_REQ-1:0]                       rsp_valid;
    logic                                     busy;
`ifdef DSP_ARB_WATCHDOG_EN
    logic                                     err_hold;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dsp_bank_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .NUM_DSP  (NUM_DSP),
        .OPW      (OPW),
        .OUTW     (OUTW),
        .DSP_LAT  (DSP_LAT)
`ifdef DSP_ARB_WATCHDOG_EN
        ,
        .MAX_HOLD (8)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_ce    (req_ce),
        .req_dsp_a (req_dsp_a),
        .req_dsp_b (req_dsp_b),
        .gnt       (gnt),
        .dsp_a     (dsp_a),
        .dsp_b     (dsp_b),
        .dsp_ce    (dsp_ce),
        .dsp_out   (dsp_out),
        .rsp_data  (rsp_data),
        .rsp_valid (rsp_valid),
        .busy      (busy)
`ifdef DSP_ARB_WATCHDOG_EN
        ,
        .err_hold  (err_hold)
`endif
    );

    // Multiplier bank: DSP_LAT stages advancing on ce.
    logic [NUM_DSP-1:0][OUTW-1:0] prod;
    logic [NUM_DSP-1:0][OUTW-1:0] mpipe [DSP_LAT];

    always_comb begin
        for (int l = 0; l < NUM_DSP; l++) begin
            prod[l] = OUTW'(dsp_a[l]) * OUTW'(dsp_b[l]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < DSP_LAT; s++) mpipe[s] <= '0;
        end else if (dsp_ce) begin
            mpipe[0] <= prod;
            for (int s = 1; s < DSP_LAT; s++) mpipe[s] <= mpipe[s-1];
        end
    end

    assign dsp_out = mpipe[DSP_LAT-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        req_ce    = '0;
        req_dsp_a = '0;
        req_dsp_b = '0;
        repeat (2) @(posedge clk);
        smp();
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_ce", 64'(dsp_ce), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rspv", 64'(rsp_valid), 64'd0);
        chk("rst_dsp_a", 64'(dsp_a[0]), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data[0]), 64'd0);
        rst_n = 1'b1;

        // First grant and a 5x7 product.
        nxt(); req = 2'b01; req_dsp_a[0][0] = 18'd5; req_dsp_b[0][0] = 18'd7;
        smp(); chk("c0_gnt", 64'(gnt), 64'd0); chk("c0_busy", 64'(busy), 64'd0);
        nxt();
        smp(); chk("c1_gnt", 64'(gnt), 64'd0); chk("c1_dsp_a", 64'(dsp_a[0]), 64'd5);
        chk("c1_busy", 64'(busy), 64'd1);
        nxt(); req_ce = 2'b01;
        smp(); chk("c2_gnt", 64'(gnt), 64'd1); chk("c2_ce", 64'(dsp_ce), 64'd1);
        nxt(); req_dsp_a[0][0] = '0; req_dsp_b[0][0] = '0;
        smp(); chk("c3_rspv", 64'(rsp_valid), 64'd0);
        nxt();
        smp(); chk("c4_rspv", 64'(rsp_valid), 64'd0);
        nxt();
        smp(); chk("c5_rspv", 64'(rsp_valid), 64'd1); chk("c5_data", 64'(rsp_data[0]), 64'd35);
        nxt(); req_ce = 2'b00;
        smp(); chk("c6_stall_rspv", 64'(rsp_valid), 64'd0); chk("c6_ce", 64'(dsp_ce), 64'd0);

        // Owner drops req while issuing 6x9; requester 1 waiting.
        nxt(); req = 2'b10; req_ce = 2'b01; req_dsp_a[0][0] = 18'd6; req_dsp_b[0][0] = 18'd9;
        req_dsp_a[1][0] = 18'd11;
        smp(); chk("d0_rspv", 64'(rsp_valid), 64'd1); chk("d0_gnt", 64'(gnt), 64'd1);
        nxt(); req_ce = 2'b00; req_dsp_a[0][0] = '0; req_dsp_b[0][0] = '0;
        smp(); chk("d1_gnt", 64'(gnt), 64'd0); chk("d1_ce", 64'(dsp_ce), 64'd1);
        chk("d1_dsp_a", 64'(dsp_a[0]), 64'd0); chk("d1_rspv", 64'(rsp_valid), 64'd1);
        nxt();
        smp(); chk("d2_ce", 64'(dsp_ce), 64'd1); chk("d2_rspv", 64'(rsp_valid), 64'd1);
        nxt();
        smp(); chk("d3_rspv", 64'(rsp_valid), 64'd1); chk("d3_data", 64'(rsp_data[0]), 64'd54);
        chk("d3_dsp_a", 64'(dsp_a[0]), 64'd0);
        nxt(); req_ce = 2'b01; req_dsp_a[0][0] = 18'd99;
        smp(); chk("d4_dsp_a_owner1", 64'(dsp_a[0]), 64'd11); chk("d4_ce_nonowner", 64'(dsp_ce), 64'd0);
        chk("d4_busy", 64'(busy), 64'd1); chk("d4_rspv", 64'(rsp_valid), 64'd0);
        nxt();
        smp(); chk("d5_gnt", 64'(gnt), 64'd2);

        // ce pattern 1,0,0,1 on owner 1: products 6 then 20.
        nxt(); req_ce = 2'b10; req_dsp_a[1][0] = 18'd2; req_dsp_b[1][0] = 18'd3;
        smp(); chk("e0_ce", 64'(dsp_ce), 64'd1); chk("e0_dsp_a", 64'(dsp_a[0]), 64'd2);
        nxt(); req_ce = 2'b01;
        smp(); chk("e1_ce", 64'(dsp_ce), 64'd0); chk("e1_rspv", 64'(rsp_valid), 64'd0);
        nxt(); req_ce = 2'b00;
        smp(); chk("e2_ce", 64'(dsp_ce), 64'd0);
        nxt(); req_ce = 2'b10; req_dsp_a[1][0] = 18'd4; req_dsp_b[1][0] = 18'd5;
        smp(); chk("e3_ce", 64'(dsp_ce), 64'd1); chk("e3_rspv", 64'(rsp_valid), 64'd0);
        nxt(); req_dsp_a[1][0] = '0; req_dsp_b[1][0] = '0;
        smp(); chk("e4_rspv", 64'(rsp_valid), 64'd0);
        nxt();
        smp(); chk("e5_rspv", 64'(rsp_valid), 64'd2); chk("e5_data", 64'(rsp_data[0]), 64'd6);
        nxt();
        smp(); chk("e6_rspv", 64'(rsp_valid), 64'd2); chk("e6_data", 64'(rsp_data[0]), 64'd20);

        // Reset during drain with results in flight.
        nxt(); req = 2'b00;
        smp(); chk("f0_ce", 64'(dsp_ce), 64'd1);
        nxt();
        smp(); chk("f1_drain_ce", 64'(dsp_ce), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", 64'(gnt), 64'd0); chk("arst_ce", 64'(dsp_ce), 64'd0);
        chk("arst_rspv", 64'(rsp_valid), 64'd0); chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_dsp_a", 64'(dsp_a[0]), 64'd0);
        @(posedge clk);
        smp(); rst_n = 1'b1; req_ce = 2'b00;
        for (int i = 0; i < 4; i++) begin
            nxt();
            smp(); chk("post_rst_rspv", 64'(rsp_valid), 64'd0); chk("post_rst_busy", 64'(busy), 64'd0);
        end

        // Simultaneous requests from IDLE, then owner re-raises during drain.
        nxt(); req = 2'b11; req_dsp_a[0][0] = 18'd21; req_dsp_a[1][0] = 18'd31;
        smp(); chk("g0_busy", 64'(busy), 64'd0);
        nxt();
        smp(); chk("g1_dsp_a_owner0", 64'(dsp_a[0]), 64'd21);
        nxt(); req = 2'b10;
        smp(); chk("g2_gnt", 64'(gnt), 64'd1);
        nxt(); req = 2'b11;
        smp(); chk("g3_gnt", 64'(gnt), 64'd0); chk("g3_ce", 64'(dsp_ce), 64'd1);
        chk("g3_dsp_a", 64'(dsp_a[0]), 64'd0);
        nxt();
        smp(); chk("g4_ce", 64'(dsp_ce), 64'd1); chk("g4_dsp_a", 64'(dsp_a[0]), 64'd0);
        nxt();
        smp(); chk("g5_ce", 64'(dsp_ce), 64'd1); chk("g5_gnt", 64'(gnt), 64'd0);
        nxt();
        smp(); chk("g6_busy", 64'(busy), 64'd1); chk("g6_dsp_a_owner1", 64'(dsp_a[0]), 64'd31);
        chk("g6_gnt", 64'(gnt), 64'd0);
        nxt();
        smp(); chk("g7_gnt", 64'(gnt), 64'd2);

`ifdef DSP_ARB_WATCHDOG_EN
        repeat (6) nxt();
        smp(); chk("wd_before", 64'(err_hold), 64'd0);
        nxt();
        smp(); chk("wd_set", 64'(err_hold), 64'd1);
        nxt(); req = 2'b01;
        repeat (5) nxt();
        smp(); chk("wd_moved_gnt", 64'(gnt), 64'd1); chk("wd_sticky", 64'(err_hold), 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsp_bank_arbiter.md
Name: dsp_bank_arbiter

Overview:
- Shares one bank of NUM_DSP multiply units between NUM_REQ compute engines (matrix multiplier, convolution engine, etc.).
- Grants are round-robin and non-preemptive. The owner drives DSP operands and clock enable through the arbiter.
- On release, the bank pipeline is drained before handover. Every result is tagged back to the requester that issued it.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- NUM_DSP, 16, DSP units in the bank.
- OPW, 18, operand width per DSP input.
- OUTW, 37, DSP result width.
- DSP_LAT, 3, DSP pipeline depth in ce-qualified cycles (≥1).
- MAX_HOLD, 1024, watchdog hold limit in cycles (optional feature only).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- req  input  NUM_REQ  level request; held high for the whole job
- req_ce  input  NUM_REQ  per-requester DSP clock enable
- req_dsp_a  input  NUM_REQ x NUM_DSP x OPW  requester A operands
- req_dsp_b  input  NUM_REQ x NUM_DSP x OPW  requester B operands
- gnt  output  NUM_REQ  one-hot grant
- dsp_a  output  NUM_DSP x OPW  operands to bank
- dsp_b  output  NUM_DSP x OPW  operands to bank
- dsp_ce  output  1  bank clock enable
- dsp_out  input  NUM_DSP x OUTW  bank results
- rsp_data  output  NUM_DSP x OUTW  dsp_out broadcast to all requesters
- rsp_valid  output  NUM_REQ  result for requester i is present on rsp_data
- busy  output  1  state != IDLE or tag pipeline non-empty

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_ptr = 0; tag pipeline cleared.
- States:
  - IDLE:
    - Any req bit set → OWN.
    - Owner is the first set bit at or after rr_ptr, cyclic.
    - gnt[owner] rises the cycle after the state is entered (registered).
  - OWN:
    - dsp_a/dsp_b = owner operands; dsp_ce = req_ce[owner]. Combinational mux from the registered owner index.
    - gnt stays high while req[owner] = 1.
    - req[owner] seen low → DRAIN; gnt cleared at the same edge.
    - rr_ptr = owner+1 mod NUM_REQ.
  - DRAIN:
    - dsp_a/dsp_b forced 0; dsp_ce = 1 for exactly DSP_LAT cycles (counter).
    - Then next owner (same search rule) → OWN, else → IDLE.
    - A pending request re-grants with no IDLE bubble.
- Any non-owner operand or ce changes have no effect on the bank.
- Tag pipeline:
  - DSP_LAT stages of {valid, owner_idx}; advances only when dsp_ce = 1.
  - Stage 0 loads valid = 1 (OWN with req_ce[owner] = 1) or valid = 0 (DRAIN bubble).
  - rsp_valid[i] = dsp_ce & last_stage.valid & (last_stage.owner == i).
  - Result latency = DSP_LAT ce-cycles after the issuing cycle.
- Simultaneous events:
  - Owner drops req in the same cycle another raises → normal DRAIN, then grant.
  - Owner re-raises req during DRAIN → treated as a new request; round-robin order applies.
- A single requester can own consecutively. It pays one DRAIN per release.
- req[owner] dropping while req_ce = 1: that final cycle's operands are still issued and tagged.
- Asynchronous reset mid-operation: everything returns to reset values immediately. In-flight results are discarded (no rsp_valid).
- gnt is always one-hot or zero. rsp_valid is at most one-hot.

Optional Feature:
- DSP_ARB_WATCHDOG_EN defined:
  - Adds output err_hold (1 bit, sticky, reset 0) and a hold counter.
  - Counter counts OWN cycles while any non-owner req = 1; it clears on each new grant.
  - Reaching MAX_HOLD sets err_hold.
  - No preemption; granting is unaffected.
- Not defined: no counter and no port. Behaviour is otherwise identical.

Decomposition:
- Shared package dsp_arb_pkg:
  - arb_state_t enum {IDLE, OWN, DRAIN}.
  - Tag struct {valid, owner_idx}.
  - Default constants: NUM_DSP = 16, OPW = 18, OUTW = 37.
- One sub-module rr_pick: combinational round-robin first-set-bit search (req, rr_ptr → idx, found).
- Tag pipeline stays inline.

Test Plan:
- Reset, then req = 2'b01 at cycle 0 → gnt = 01 at cycle 2. dsp_a follows req_dsp_a[0]. A product issued with ce = 1 gives rsp_valid[0] exactly 3 cycles later, with rsp_data equal to the product (e.g. 5×7 = 35).
- req = 2'b11 simultaneously from IDLE with rr_ptr = 0 → requester 0 granted. Drop req[0] → 3 DRAIN cycles with dsp_a = 0 and dsp_ce = 1, then gnt = 10 with no IDLE cycle.
- Owner 0 drops req in the same cycle it issues its last operand → that result still arrives as rsp_valid[0]. rsp_valid[1] never asserts for tag-0 data.
- req_ce[owner] toggles 1,0,0,1 → dsp_ce follows. The tag pipeline stalls, so result spacing matches issue spacing in ce cycles.
- Assert rst_n = 0 during DRAIN with 2 results in flight → all outputs 0 immediately. No rsp_valid after reset release.
- With DSP_ARB_WATCHDOG_EN and MAX_HOLD = 8: owner 0 holds while req[1] = 1 → err_hold = 1 on the 8th contended cycle and stays 1 after the grant moves.
